// File: rtl/dsi_serial_rx.sv
// -----------------------------------------------------------------------------
// dsi_serial_rx
//
// Purpose:
//   Receive-side checker for the SerialP/SerialN differential lane. Both lanes
//   are synchronized into the serial clock domain. 8-bit frames are recovered
//   from serial_p (start bit 0, 8 data bits LSB first, stop bit 1). Each frame
//   reports one of two results: a good byte or a framing error. The frame also
//   reports whether the pair was ever non-complementary at a sample point. A
//   wrapping counter tracks the number of good bytes.
//
// Ports:
//   clk        in   serial-domain clock; all logic on the rising edge
//   rst        in   asynchronous active-low reset
//   serial_p   in   positive lane (async to clk, idle high); data source
//   serial_n   in   negative lane (async to clk), nominally ~serial_p
//   rx_data    out  last good byte, held until the next good frame
//   rx_valid   out  one-cycle pulse when rx_data has been updated
//   frame_err  out  one-cycle pulse when the stop bit was sampled 0
//   diff_err   out  one-cycle pulse at frame end if any sample saw p == n
//   busy       out  high while the receiver is not idle
//   byte_count out  number of good frames, wraps silently
// -----------------------------------------------------------------------------
module dsi_serial_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serial_p,
  input  logic               serial_n,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               diff_err,
  output logic               busy,
  output logic [COUNT_W-1:0] byte_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Two-flop synchronizers, lane 0 = serial_p, lane 1 = serial_n.
  logic [1:0] lane_in;
  logic [1:0] sync_a_q;
  logic [1:0] sync_b_q;

  assign lane_in = {serial_n, serial_p};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_a_q[gi] <= 1'b0;
          sync_b_q[gi] <= 1'b0;
        end else begin
          sync_a_q[gi] <= lane_in[gi];
          sync_b_q[gi] <= sync_a_q[gi];
        end
      end
    end
  endgenerate

  logic sync_p;
  logic sync_n;
  logic pair_eq;

  assign sync_p  = sync_b_q[0];
  assign sync_n  = sync_b_q[1];
  assign pair_eq = (sync_p == sync_n);

  // prev resets to 0 so a line held low out of reset never looks like a start edge.
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_p;
    end
  end

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               flag_q;
  logic [7:0]         rx_data_q;
  logic               rx_valid_q;
  logic               frame_err_q;
  logic               diff_err_q;
  logic               busy_q;
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      flag_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      diff_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      // Result pulses last exactly one cycle.
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      diff_err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // A start edge is accepted even in the cycle the previous frame's
          // result pulse is being presented, so zero-gap frames work.
          if (!sync_p && prev_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (sync_p) begin
              // Line already back high at mid-bit: a glitch, drop silently.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
              if (pair_eq) begin
                flag_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= sync_p;
            if (pair_eq) begin
              flag_q <= 1'b1;
            end
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            // The stop sample itself also takes part in the pair check.
            diff_err_q <= flag_q | pair_eq;
            if (sync_p) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              count_q    <= count_q + COUNT_W'(1);
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign diff_err   = diff_err_q;
  assign busy       = busy_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_dsi_serial_rx.sv
`timescale 1ns/1ps
module tb_dsi_serial_rx;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        serial_p = 1'b1;
  logic        serial_n = 1'b0;

  logic [7:0]  rx_data,  rx_data4;
  logic        rx_valid, rx_valid4;
  logic        frame_err, frame_err4;
  logic        diff_err, diff_err4;
  logic        busy, busy4;
  logic [15:0] byte_count;
  logic [3:0]  byte_count4;

  dsi_serial_rx #(.CLKS_PER_BIT(CPB), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .serial_p(serial_p), .serial_n(serial_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .diff_err(diff_err), .busy(busy), .byte_count(byte_count)
  );

  dsi_serial_rx #(.CLKS_PER_BIT(CPB), .COUNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .serial_p(serial_p), .serial_n(serial_n),
    .rx_data(rx_data4), .rx_valid(rx_valid4), .frame_err(frame_err4),
    .diff_err(diff_err4), .busy(busy4), .byte_count(byte_count4)
  );

  always #25 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observed result events (recorded on the falling edge).
  typedef struct {
    bit v, f, d;
    logic [7:0] data;
    logic [15:0] c16;
    bit v4, f4, d4;
    logic [3:0] c4;
    int at;
  } obs_t;
  obs_t obs_q[$];

  // Expected result events from the reference model.
  typedef struct {
    bit v, f, d;
    logic [7:0] data;
    logic [15:0] c16;
    logic [3:0] c4;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_data = 8'h00;
  int         m_cnt = 0;
  int         busy_samples = 0;
  int         last_start_cyc = 0;

  always @(negedge clk) begin
    obs_t o;
    if (rx_valid || frame_err || diff_err || rx_valid4 || frame_err4 || diff_err4) begin
      o.v = rx_valid; o.f = frame_err; o.d = diff_err;
      o.data = rx_data; o.c16 = byte_count;
      o.v4 = rx_valid4; o.f4 = frame_err4; o.d4 = diff_err4;
      o.c4 = byte_count4; o.at = cyc;
      obs_q.push_back(o);
    end
    if (busy) busy_samples = busy_samples + 1;
  end

  // Reference model: the outcome of a frame depends only on its stop bit
  // and on whether any bit period had the pair non-complementary.
  task automatic model_frame(input logic [7:0] b, input bit stop, input int diff_idx);
    exp_t e;
    if (stop) begin
      m_data = b;
      m_cnt  = m_cnt + 1;
    end
    e.v = stop; e.f = !stop; e.d = (diff_idx >= 0 && diff_idx <= 9);
    e.data = m_data; e.c16 = 16'(m_cnt % 65536); e.c4 = 4'(m_cnt % 16);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_cnt  = 0;
  endtask

  // Called and returns at posedge+1.
  task automatic drive_bit(input logic p, input logic n);
    serial_p = p;
    serial_n = n;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // diff_idx: 0 = start bit, 1..8 = data bits 0..7, 9 = stop bit, -1 = none.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int diff_idx,
                            input int gap_bits);
    logic bv;
    model_frame(b, stop, diff_idx);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      bv = 1'b0;
      else if (k == 9) bv = stop;
      else             bv = b[k-1];
      if (k == 0) last_start_cyc = cyc;
      drive_bit(bv, (k == diff_idx) ? bv : ~bv);
    end
    for (int g = 0; g < gap_bits; g++) drive_bit(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    serial_p = 1'b1;
    serial_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_data, rx_valid, frame_err, diff_err, busy, byte_count} !== 28'h0) begin
      failures++;
      $display("FAIL reset_state got data=%h v=%b f=%b d=%b busy=%b cnt=%0d want all zero",
               rx_data, rx_valid, frame_err, diff_err, busy, byte_count);
    end
    checks++;
    if ({rx_data4, rx_valid4, frame_err4, diff_err4, busy4, byte_count4} !== 16'h0) begin
      failures++;
      $display("FAIL reset_state_w4 got data=%h v=%b f=%b d=%b busy=%b cnt=%0d want all zero",
               rx_data4, rx_valid4, frame_err4, diff_err4, busy4, byte_count4);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b events=%0d want busy=0 events=0",
               busy, obs_q.size());
    end
  endtask

  task automatic test_basic();
    obs_t o;
    int lat;
    send_frame(8'hA5, 1'b1, -1, 2);
    void'(exp_q.pop_front());
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL basic_events got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if ({o.v, o.f, o.d, o.data, o.c16} !== {3'b100, 8'hA5, 16'd1}) begin
        failures++;
        $display("FAIL basic_result got v=%b f=%b d=%b data=%h cnt=%0d want v=1 f=0 d=0 data=a5 cnt=1",
                 o.v, o.f, o.d, o.data, o.c16);
      end
      // Pin fall -> t0 is 3 edges; stop sample at t0+CPB/2+9*CPB; visible one edge later.
      lat = o.at + 1 - last_start_cyc;
      checks++;
      if (lat < 3 + CPB/2 + 9*CPB || lat > 3 + CPB/2 + 9*CPB + 2) begin
        failures++;
        $display("FAIL basic_latency got %0d want %0d (+1)", lat, 3 + CPB/2 + 9*CPB + 1);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    obs_t o;
    send_frame(8'h3C, 1'b0, -1, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 30; i++) drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL frame_err_events got %0d want 1 (stuck-low line must stay silent)", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if ({o.v, o.f, o.d, o.data, o.c16} !== {3'b010, 8'hA5, 16'd1}) begin
        failures++;
        $display("FAIL frame_err_result got v=%b f=%b d=%b data=%h cnt=%0d want v=0 f=1 d=0 data=a5 cnt=1",
                 o.v, o.f, o.d, o.data, o.c16);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    busy_samples = 0;
    serial_p = 1'b0;
    serial_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    serial_p = 1'b1;
    serial_n = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy_samples != CPB/2) begin
      failures++;
      $display("FAIL glitch_busy got %0d busy cycles want %0d", busy_samples, CPB/2);
    end
    checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_quiet got events=%0d busy=%b want events=0 busy=0", obs_q.size(), busy);
    end
    obs_q.delete();
  endtask

  task automatic test_diff();
    obs_t o;
    send_frame(8'h81, 1'b1, 4, 2);
    void'(exp_q.pop_front());
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL diff_events got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if ({o.v, o.f, o.d, o.data, o.c16} !== {3'b101, 8'h81, 16'd2}) begin
        failures++;
        $display("FAIL diff_result got v=%b f=%b d=%b data=%h cnt=%0d want v=1 f=0 d=1 data=81 cnt=2",
                 o.v, o.f, o.d, o.data, o.c16);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_abort();
    obs_t o;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    drive_bit(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) drive_bit(b[k], ~b[k]);
    serial_p = b[5];
    serial_n = ~b[5];
    repeat (CPB/2) @(posedge clk);
    #1;
    rst = 1'b0;
    serial_p = 1'b1;
    serial_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || byte_count !== 16'd0 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL abort_reset got busy=%b cnt=%0d data=%h want 0 0 00", busy, byte_count, rx_data);
    end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL abort_no_pulse got %0d events want 0", obs_q.size());
    end
    obs_q.delete();
    send_frame(8'h55, 1'b1, -1, 2);
    void'(exp_q.pop_front());
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL abort_next_events got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if ({o.v, o.f, o.d, o.data, o.c16} !== {3'b100, 8'h55, 16'd1}) begin
        failures++;
        $display("FAIL abort_next_result got v=%b f=%b d=%b data=%h cnt=%0d want v=1 f=0 d=0 data=55 cnt=1",
                 o.v, o.f, o.d, o.data, o.c16);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    int n_valid;
    do_reset();
    for (int i = 0; i < 17; i++)
      send_frame(8'($urandom_range(0, 255)), 1'b1, -1, (i == 16) ? 2 : 0);
    n_valid = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_missing want v=%b data=%h cnt=%0d got no event", e.v, e.data, e.c16);
      end else begin
        o = obs_q.pop_front();
        if (o.v) n_valid++;
        if ({o.v, o.f, o.d, o.data, o.c16} !== {e.v, e.f, e.d, e.data, e.c16}) begin
          failures++;
          $display("FAIL b2b_event got v=%b f=%b d=%b data=%h cnt=%0d want v=%b f=%b d=%b data=%h cnt=%0d",
                   o.v, o.f, o.d, o.data, o.c16, e.v, e.f, e.d, e.data, e.c16);
        end
        checks++;
        if ({o.v4, o.f4, o.d4, o.c4} !== {e.v, e.f, e.d, e.c4}) begin
          failures++;
          $display("FAIL b2b_w4 got v=%b f=%b d=%b cnt=%0d want v=%b f=%b d=%b cnt=%0d",
                   o.v4, o.f4, o.d4, o.c4, e.v, e.f, e.d, e.c4);
        end
      end
    end
    checks++;
    if (n_valid != 17 || obs_q.size() != 0 || byte_count4 !== 4'd1 || byte_count !== 16'd17) begin
      failures++;
      $display("FAIL b2b_total got valid=%0d extra=%0d cnt4=%0d cnt16=%0d want 17 0 1 17",
               n_valid, obs_q.size(), byte_count4, byte_count);
    end
    obs_q.delete();
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit stop;
    int didx;
    for (int i = 0; i < 24; i++) begin
      stop = ($urandom_range(0, 3) != 0);
      didx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      // After a low stop bit the line must go high again before the next start.
      send_frame(8'($urandom_range(0, 255)), stop, didx,
                 stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end
    drive_bit(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL rand_missing want v=%b f=%b d=%b data=%h got no event", e.v, e.f, e.d, e.data);
      end else begin
        o = obs_q.pop_front();
        if ({o.v, o.f, o.d, o.data, o.c16} !== {e.v, e.f, e.d, e.data, e.c16}) begin
          failures++;
          $display("FAIL rand_event got v=%b f=%b d=%b data=%h cnt=%0d want v=%b f=%b d=%b data=%h cnt=%0d",
                   o.v, o.f, o.d, o.data, o.c16, e.v, e.f, e.d, e.data, e.c16);
        end
        checks++;
        if ({o.v4, o.f4, o.d4, o.c4} !== {e.v, e.f, e.d, e.c4}) begin
          failures++;
          $display("FAIL rand_w4 got v=%b f=%b d=%b cnt=%0d want v=%b f=%b d=%b cnt=%0d",
                   o.v4, o.f4, o.d4, o.c4, e.v, e.f, e.d, e.c4);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rand_extra got %0d unexpected events want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_diff();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
